morse_encoder_tx: RTL and testbench
===================================

Name: morse_encoder_tx

Overview:
- Transmit-side counterpart of the Morse receive path: accepts one 5-bit character code per valid/ready handshake and drives a timed on/off key line.
- Code space is shared with the receive decoder: A..Z = 0..25, SPACE = 26, 27..31 invalid.
- Element patterns use the decoder convention:
  - dot = 0, dash = 1.
  - Element length 1..4.
  - First element sits at bit pat_len-1.
- Sits between the character source (UART/keypad FIFO) and the key/LED/buzzer driver. Supports loopback against the decoder.

Parameters:
- UNIT_CYCLES, 4, clock cycles per Morse time unit (>=2; board build overrides, e.g. 6_000_000).
- UNIT_W, 24, width of the unit cycle counter; must hold UNIT_CYCLES-1.
- DASH_UNITS, 3, mark length of a dash in units.
- LETTER_GAP_UNITS, 3, key-low time after the last element of a letter.
- WORD_GAP_UNITS, 7, key-low time for SPACE.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- char_valid  in  1  char_code is valid.
- char_code  in  5  character code (0..25 letters, 26 SPACE).
- char_ready  out  1  block accepts a character this cycle.
- key_out  out  1  registered key line, 1 = mark (tone on).
- busy  out  1  registered; 1 while a character is being sent, including its trailing gap.
- err_invalid  out  1  one-cycle pulse: an accepted code was 27..31.
- pat_len  out  4  element count of the last accepted code; 4 for SPACE.
- pat_bits  out  4  element pattern of the last accepted code; 1111 for SPACE.

Behaviour:
- Reset (rst=0 at a clock edge): the following take effect at the next edge, regardless of state, and any in-flight character is discarded.
  - state=IDLE.
  - key_out=0, busy=0, err_invalid=0, pat_len=0, pat_bits=0.
  - Unit counter and element index cleared.
- char_ready = rst && (state==IDLE). It is combinational and is 0 while rst=0.
- Accept occurs on an edge k with char_valid && char_ready. At k:
  - pat_len/pat_bits load from the lookup table.
  - The state transition is taken.
- Lookup table:
  - E:1/0, T:1/1.
  - I:2/00, A:01, N:10, M:11.
  - S:3/000, U:001, R:010, W:011, D:100, K:101, G:110, O:111.
  - H:4/0000, V:0001, F:0010, L:0100, P:0110, J:0111, B:1000, X:1001, C:1010, Y:1011, Z:1100, Q:1101.
- States:
  - IDLE: key_out=0, busy=0.
    - Letter accepted -> MARK, element index = pat_len-1.
    - SPACE -> WORD_GAP.
    - Invalid -> stays IDLE; err_invalid=1 for cycle k+1 only; pat_len/pat_bits=0; char_ready stays 1.
  - MARK: key_out=1. Duration 1 unit (bit 0) or DASH_UNITS units (bit 1).
    - At end, if index>0 -> ELEM_GAP.
    - Else -> LETTER_GAP.
  - ELEM_GAP: key_out=0 for 1 unit; index decrements; -> MARK.
  - LETTER_GAP: key_out=0 for LETTER_GAP_UNITS units; -> IDLE.
  - WORD_GAP: key_out=0 for WORD_GAP_UNITS units; -> IDLE.
- Timing: key_out and busy are registered.
  - First mark occupies cycles k+1..k+U·len, where U = UNIT_CYCLES.
  - Each segment is exactly an integer number of units × U cycles, with no dead cycles between segments.
  - The next accept is possible on the edge immediately following the last gap cycle.
- Character durations:
  - Letter: (sum of mark units + (len-1) + LETTER_GAP_UNITS)·U cycles. Example: E = 4U.
  - SPACE: 7U cycles.
- Unit counter counts 0..U-1 and issues a unit tick at U-1. A segment counter counts ticks. Both restart on every state change.
- char_valid held high while busy: ignored (no accept); the code is taken when the block returns to IDLE.
- char_code changes while char_ready=0: no effect.
- Invalid code never disturbs key_out.
- Reset during MARK: key_out falls at the next edge. No partial letter resumes.

Decomposition:
- morse_pkg:
  - Character code constants A_M..Z_M, SPACE_M=26, INVALID_M=27.
  - Unit multipliers.
  - State enumeration {IDLE, MARK, ELEM_GAP, LETTER_GAP, WORD_GAP}.
  - Lookup function code -> {len[3:0], bits[3:0], valid}.
  - The same table is the single source of truth for the decoder's cases.
- Sub-module morse_unit_timer:
  - Parameters UNIT_CYCLES, UNIT_W.
  - Inputs: clk, rst, restart.
  - Output: unit_tick pulse.

Test Plan:
- U=4, send E(4) -> key_out=1 cycles k+1..k+4, low k+5..k+16; char_ready=1 again at k+17; pat_len=1, pat_bits=0000.
- U=4, send A(0) -> key high 4, low 4, high 12, low 12 cycles; busy=1 for 32 cycles; pat_len=2, pat_bits=0001.
- U=4, send SPACE(26) -> key_out stays 0; busy=1 for 28 cycles; pat_len=4, pat_bits=1111.
- Send 27 -> err_invalid=1 for exactly one cycle, key_out=0, busy=0; char_ready never drops; then Q(16) is accepted on the next edge with pattern 1101.
- Back-to-back: char_valid held high with S(18) then O(14) -> O accepted on the edge right after S's letter gap ends; key marks are 3×4 dot then 3×12 dash cycles.
- Reset: rst=0 during the dash of T(19) -> next edge key_out=0, busy=0, pat_len=0; after rst=1, char_ready=1 and M(12) sends two 12-cycle marks.
- Loopback: all 27 codes -> key_out decoded by the receive decoder path reproduces each code.

Source files
------------

// File: rtl/morse_encoder_tx_pkg.sv
// Shared Morse definitions: character codes, state encoding and the code -> element pattern table.
// The table is the single source of truth for both the transmit encoder and the receive decoder.
package morse_encoder_tx_pkg;

    localparam logic [4:0] A_M = 5'd0,  B_M = 5'd1,  C_M = 5'd2,  D_M = 5'd3,  E_M = 5'd4;
    localparam logic [4:0] F_M = 5'd5,  G_M = 5'd6,  H_M = 5'd7,  I_M = 5'd8,  J_M = 5'd9;
    localparam logic [4:0] K_M = 5'd10, L_M = 5'd11, M_M = 5'd12, N_M = 5'd13, O_M = 5'd14;
    localparam logic [4:0] P_M = 5'd15, Q_M = 5'd16, R_M = 5'd17, S_M = 5'd18, T_M = 5'd19;
    localparam logic [4:0] U_M = 5'd20, V_M = 5'd21, W_M = 5'd22, X_M = 5'd23, Y_M = 5'd24;
    localparam logic [4:0] Z_M = 5'd25, SPACE_M = 5'd26, INVALID_M = 5'd27;

    localparam int SEG_W = 8;
    localparam logic [SEG_W-1:0] DOT_UNITS      = 8'd1;
    localparam logic [SEG_W-1:0] ELEM_GAP_UNITS = 8'd1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MARK       = 3'd1,
        ELEM_GAP   = 3'd2,
        LETTER_GAP = 3'd3,
        WORD_GAP   = 3'd4
    } state_t;

    // bits: dot = 0, dash = 1, first element at bit len-1
    typedef struct packed {
        logic [3:0] len;
        logic [3:0] bits;
        logic       valid;
    } morse_lut_t;

    function automatic morse_lut_t morse_lookup(input logic [4:0] code);
        morse_lut_t r;
        if (code >= INVALID_M) begin
            r = {4'd0, 4'b0000, 1'b0};
        end else begin
            case (code)
                A_M:     r = {4'd2, 4'b0001, 1'b1};
                B_M:     r = {4'd4, 4'b1000, 1'b1};
                C_M:     r = {4'd4, 4'b1010, 1'b1};
                D_M:     r = {4'd3, 4'b0100, 1'b1};
                E_M:     r = {4'd1, 4'b0000, 1'b1};
                F_M:     r = {4'd4, 4'b0010, 1'b1};
                G_M:     r = {4'd3, 4'b0110, 1'b1};
                H_M:     r = {4'd4, 4'b0000, 1'b1};
                I_M:     r = {4'd2, 4'b0000, 1'b1};
                J_M:     r = {4'd4, 4'b0111, 1'b1};
                K_M:     r = {4'd3, 4'b0101, 1'b1};
                L_M:     r = {4'd4, 4'b0100, 1'b1};
                M_M:     r = {4'd2, 4'b0011, 1'b1};
                N_M:     r = {4'd2, 4'b0010, 1'b1};
                O_M:     r = {4'd3, 4'b0111, 1'b1};
                P_M:     r = {4'd4, 4'b0110, 1'b1};
                Q_M:     r = {4'd4, 4'b1101, 1'b1};
                R_M:     r = {4'd3, 4'b0010, 1'b1};
                S_M:     r = {4'd3, 4'b0000, 1'b1};
                T_M:     r = {4'd1, 4'b0001, 1'b1};
                U_M:     r = {4'd3, 4'b0001, 1'b1};
                V_M:     r = {4'd4, 4'b0001, 1'b1};
                W_M:     r = {4'd3, 4'b0011, 1'b1};
                X_M:     r = {4'd4, 4'b1001, 1'b1};
                Y_M:     r = {4'd4, 4'b1011, 1'b1};
                Z_M:     r = {4'd4, 4'b1100, 1'b1};
                SPACE_M: r = {4'd4, 4'b1111, 1'b1};
                default: r = {4'd0, 4'b0000, 1'b0};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_encoder_tx_if.sv
// Character handshake plus key line and status between a character source and the Morse encoder.
interface morse_encoder_tx_if;
    logic       char_valid;
    logic [4:0] char_code;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err_invalid;
    logic [3:0] pat_len;
    logic [3:0] pat_bits;

    modport master (
        output char_valid, char_code,
        input  char_ready, key_out, busy, err_invalid, pat_len, pat_bits
    );

    modport slave (
        input  char_valid, char_code,
        output char_ready, key_out, busy, err_invalid, pat_len, pat_bits
    );
endinterface

// File: rtl/morse_encoder_tx_unit_timer.sv
// Morse time-unit divider: counts 0..UNIT_CYCLES-1 and ticks on the last cycle of each unit.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 4,
    parameter int UNIT_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic unit_tick
);
    localparam logic [UNIT_W-1:0] LAST_CNT = UNIT_W'(UNIT_CYCLES - 1);

    logic [UNIT_W-1:0] cnt_r;

    // unit cycle counter, realigned to zero whenever the encoder changes state
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {UNIT_W{1'b0}};
        end else if (restart || (cnt_r == LAST_CNT)) begin
            cnt_r <= {UNIT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(UNIT_W-1){1'b0}}, 1'b1};
        end
    end

    assign unit_tick = (cnt_r == LAST_CNT);
endmodule

// File: rtl/morse_encoder_tx.sv
// Morse transmitter: takes one character code per valid/ready handshake and keys it out
// as timed marks and gaps; key_out, busy and status are registered from the next state.
module morse_encoder_tx
    import morse_encoder_tx_pkg::*;
#(
    parameter int UNIT_CYCLES      = 4,
    parameter int UNIT_W           = 24,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7
) (
    input  logic               clk,
    input  logic               rst,
    morse_encoder_tx_if.slave  bus
);
    state_t           state_r, state_s;
    morse_lut_t       lut_s;
    logic [3:0]       pat_len_r, pat_bits_r;
    logic [1:0]       idx_r;
    logic [SEG_W-1:0] seg_r, seg_units_s;
    logic             key_r, busy_r, err_r;
    logic             ready_s, accept_s, unit_tick_s, seg_done_s, restart_s;

    assign lut_s      = morse_lookup(bus.char_code);
    assign ready_s    = rst && (state_r == IDLE);
    assign accept_s   = bus.char_valid && ready_s;
    assign restart_s  = (state_s != state_r);
    assign seg_done_s = unit_tick_s && (seg_r == (seg_units_s - 8'd1));

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .UNIT_W      (UNIT_W)
    ) u_unit_timer (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart_s),
        .unit_tick (unit_tick_s)
    );

    // length in units of the segment the current state is timing
    always_comb begin
        seg_units_s = DOT_UNITS;
        case (state_r)
            MARK: begin
                if (pat_bits_r[idx_r]) seg_units_s = SEG_W'(DASH_UNITS);
                else                   seg_units_s = DOT_UNITS;
            end
            ELEM_GAP:   seg_units_s = ELEM_GAP_UNITS;
            LETTER_GAP: seg_units_s = SEG_W'(LETTER_GAP_UNITS);
            WORD_GAP:   seg_units_s = SEG_W'(WORD_GAP_UNITS);
            default:    seg_units_s = DOT_UNITS;
        endcase
    end

    // next-state logic; invalid codes are accepted but leave the FSM in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && lut_s.valid) begin
                    if (bus.char_code == SPACE_M) state_s = WORD_GAP;
                    else                          state_s = MARK;
                end else begin
                    state_s = IDLE;
                end
            end
            MARK: begin
                if (seg_done_s) begin
                    if (idx_r != 2'd0) state_s = ELEM_GAP;
                    else               state_s = LETTER_GAP;
                end else begin
                    state_s = MARK;
                end
            end
            ELEM_GAP: begin
                if (seg_done_s) state_s = MARK;
                else            state_s = ELEM_GAP;
            end
            LETTER_GAP, WORD_GAP: begin
                if (seg_done_s) state_s = IDLE;
                else            state_s = state_r;
            end
            default: state_s = IDLE;
        endcase
    end

    // state, pattern, element index, segment counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            pat_len_r  <= 4'd0;
            pat_bits_r <= 4'b0000;
            idx_r      <= 2'd0;
            seg_r      <= {SEG_W{1'b0}};
            key_r      <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            key_r   <= (state_s == MARK);
            busy_r  <= (state_s != IDLE);
            err_r   <= accept_s && !lut_s.valid;
            if (accept_s) begin
                pat_len_r  <= lut_s.len;
                pat_bits_r <= lut_s.bits;
                idx_r      <= lut_s.len[1:0] - 2'd1;
            end else if ((state_r == ELEM_GAP) && seg_done_s) begin
                idx_r <= idx_r - 2'd1;
            end
            if (restart_s) begin
                seg_r <= {SEG_W{1'b0}};
            end else if (unit_tick_s) begin
                seg_r <= seg_r + 8'd1;
            end
        end
    end

    assign bus.char_ready  = ready_s;
    assign bus.key_out     = key_r;
    assign bus.busy        = busy_r;
    assign bus.err_invalid = err_r;
    assign bus.pat_len     = pat_len_r;
    assign bus.pat_bits    = pat_bits_r;
endmodule

// File: tb/tb_morse_encoder_tx.sv
// Self-checking bench for morse_encoder_tx: table of all codes decoded back from key_out,
// plus hand sequences for invalid codes, back-to-back characters and reset mid-letter.
module tb_morse_encoder_tx;
    localparam int U = 4;

    typedef struct {
        int code;
        int len;
        int bits;
    } vec_t;

    typedef struct {
        int code;
        int pat_len;
        int pat_bits;
        int dec_len;
        int dec_bits;
        int busy_cycles;
        int tail_gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[27];
    exp_t sb[$];

    morse_encoder_tx_if bus();

    morse_encoder_tx #(
        .UNIT_CYCLES      (U),
        .UNIT_W           (24),
        .DASH_UNITS       (3),
        .LETTER_GAP_UNITS (3),
        .WORD_GAP_UNITS   (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int model_busy(input int len, input int bits, input bit space);
        int s = 0;
        if (space) return 7 * U;
        for (int i = 0; i < len; i++) s += bits[i] ? 3 : 1;
        return (s + (len - 1) + 3) * U;
    endfunction

    // walks key_out from the first busy cycle to the first idle cycle, decoding marks
    task automatic capture(output int n_busy, output int dlen, output int dbits,
                           output int bad_runs, output int tail);
        int mark = 0;
        int gap = 0;
        n_busy = 0; dlen = 0; dbits = 0; bad_runs = 0;
        while (bus.busy && n_busy < 400) begin
            n_busy++;
            if (bus.key_out) begin
                if (gap > 0 && dlen > 0 && gap != U) bad_runs++;
                gap = 0;
                mark++;
            end else begin
                if (mark > 0) begin
                    dbits = (dbits << 1) | ((mark == 3 * U) ? 1 : 0);
                    dlen++;
                    if (mark != U && mark != 3 * U) bad_runs++;
                end
                mark = 0;
                gap++;
            end
            @(posedge clk); #1;
        end
        if (mark > 0) bad_runs++;
        tail = gap;
    endtask

    function automatic exp_t make_exp(input int code, input int len, input int bits);
        exp_t e;
        bit   space = (code == 26);
        e.code        = code;
        e.pat_len     = len;
        e.pat_bits    = bits;
        e.dec_len     = space ? 0 : len;
        e.dec_bits    = space ? 0 : bits;
        e.busy_cycles = model_busy(len, bits, space);
        e.tail_gap    = space ? 7 * U : 3 * U;
        return e;
    endfunction

    // called one cycle after the accept edge
    task automatic check_char();
        exp_t e;
        int   nb, dl, db, br, tl, pl, pb, fk;
        pl = int'(bus.pat_len);
        pb = int'(bus.pat_bits);
        fk = int'(bus.key_out);
        chk("err_on_valid", int'(bus.err_invalid), 0);
        capture(nb, dl, db, br, tl);
        e = sb.pop_front();
        chk($sformatf("pat_len[%0d]", e.code), pl, e.pat_len);
        chk($sformatf("pat_bits[%0d]", e.code), pb, e.pat_bits);
        chk($sformatf("first_key[%0d]", e.code), fk, (e.dec_len > 0) ? 1 : 0);
        chk($sformatf("busy_cycles[%0d]", e.code), nb, e.busy_cycles);
        chk($sformatf("dec_len[%0d]", e.code), dl, e.dec_len);
        chk($sformatf("dec_bits[%0d]", e.code), db, e.dec_bits);
        chk($sformatf("run_lengths[%0d]", e.code), br, 0);
        chk($sformatf("tail_gap[%0d]", e.code), tl, e.tail_gap);
        chk($sformatf("ready_after[%0d]", e.code), int'(bus.char_ready), 1);
        chk($sformatf("key_idle[%0d]", e.code), int'(bus.key_out), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.char_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", int'(bus.char_ready), 1);
    endtask

    task automatic send(input int code, input int len, input int bits);
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_code  = 5'(code);
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        sb.push_back(make_exp(code, len, bits));
        check_char();
    endtask

    initial begin
        int nb, dl, db, br, tl;
        tbl[0]  = '{0, 2, 4'b0001};  tbl[1]  = '{1, 4, 4'b1000};  tbl[2]  = '{2, 4, 4'b1010};
        tbl[3]  = '{3, 3, 4'b0100};  tbl[4]  = '{4, 1, 4'b0000};  tbl[5]  = '{5, 4, 4'b0010};
        tbl[6]  = '{6, 3, 4'b0110};  tbl[7]  = '{7, 4, 4'b0000};  tbl[8]  = '{8, 2, 4'b0000};
        tbl[9]  = '{9, 4, 4'b0111};  tbl[10] = '{10, 3, 4'b0101}; tbl[11] = '{11, 4, 4'b0100};
        tbl[12] = '{12, 2, 4'b0011}; tbl[13] = '{13, 2, 4'b0010}; tbl[14] = '{14, 3, 4'b0111};
        tbl[15] = '{15, 4, 4'b0110}; tbl[16] = '{16, 4, 4'b1101}; tbl[17] = '{17, 3, 4'b0010};
        tbl[18] = '{18, 3, 4'b0000}; tbl[19] = '{19, 1, 4'b0001}; tbl[20] = '{20, 3, 4'b0001};
        tbl[21] = '{21, 4, 4'b0001}; tbl[22] = '{22, 3, 4'b0011}; tbl[23] = '{23, 4, 4'b1001};
        tbl[24] = '{24, 4, 4'b1011}; tbl[25] = '{25, 4, 4'b1100}; tbl[26] = '{26, 4, 4'b1111};

        bus.char_valid = 1'b0;
        bus.char_code  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key", int'(bus.key_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err_invalid), 0);
        chk("rst_pat_len", int'(bus.pat_len), 0);
        chk("rst_pat_bits", int'(bus.pat_bits), 0);
        chk("rst_ready", int'(bus.char_ready), 0);
        rst = 1'b1;
        #1;
        chk("ready_out_of_rst", int'(bus.char_ready), 1);

        // every code, decoded back from the key line
        for (int i = 0; i < 27; i++) send(tbl[i].code, tbl[i].len, tbl[i].bits);

        // invalid codes pulse err for one cycle, then Q is taken on the very next edge
        for (int c = 27; c < 32; c++) begin
            wait_ready();
            bus.char_valid = 1'b1;
            bus.char_code  = 5'(c);
            @(posedge clk); #1;
            chk("inv_err", int'(bus.err_invalid), 1);
            chk("inv_key", int'(bus.key_out), 0);
            chk("inv_busy", int'(bus.busy), 0);
            chk("inv_pat_len", int'(bus.pat_len), 0);
            chk("inv_pat_bits", int'(bus.pat_bits), 0);
            chk("inv_ready", int'(bus.char_ready), 1);
            bus.char_code = 5'd16;
            @(posedge clk); #1;
            bus.char_valid = 1'b0;
            sb.push_back(make_exp(16, 4, 4'b1101));
            check_char();
        end

        // back-to-back S then O with char_valid held high
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_code  = 5'd18;
        @(posedge clk); #1;
        bus.char_code = 5'd14;
        sb.push_back(make_exp(18, 3, 4'b0000));
        check_char();
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        sb.push_back(make_exp(14, 3, 4'b0111));
        check_char();

        // reset during the dash of T, then M must send cleanly
        wait_ready();
        bus.char_valid = 1'b1;
        bus.char_code  = 5'd19;
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("t_dash_key", int'(bus.key_out), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_key", int'(bus.key_out), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_pat_len", int'(bus.pat_len), 0);
        chk("mid_rst_ready", int'(bus.char_ready), 0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", int'(bus.char_ready), 1);
        capture(nb, dl, db, br, tl);
        chk("no_resume_busy", nb, 0);
        send(12, 2, 4'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
